// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequential 4-channel scanner driving a 4:1 mux select
// Optional macro MUX_SCAN_CONT_EN: repeat scans back-to-back until abort.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      data_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = SCAN;
          sel_d    = 2'd0;
          cnt_d    = 4'd0;
          shadow_d = 4'd0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          sel_d   = 2'd0;
          cnt_d   = 4'd0;
        end else if (cnt_q == LAST) begin
          cnt_d           = 4'd0;
          shadow_d[sel_q] = mux_out;
          if (sel_q == 2'd3) begin
            // Publish with the final bit merged so data is valid while done is high.
            state_d = DONE;
            sel_d   = 2'd0;
            data_d  = {mux_out, shadow_q[2:0]};
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
`ifdef MUX_SCAN_CONT_EN
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d  = SCAN;
          shadow_d = 4'd0;
        end
`else
        state_d = IDLE;
`endif
        sel_d = 2'd0;
        cnt_d = 4'd0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign sel  = sel_q;
  assign data = data_q;
  assign busy = (state_q == SCAN) || (state_q == DONE);
  assign done = (state_q == DONE);

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, meaning cycles each channel is held on sel before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one 4-channel scan; sampled only in IDLE.
REQ-005 abort  input  1  terminate an active scan; no result published.
REQ-006 mux_out  input  1  selected bit returned by the downstream 4:1 mux.
REQ-007 sel  output  2  channel select driven to the 4:1 mux, registered.
REQ-008 data  output  4  last completed scan result; bit k = mux_out sampled with sel==k.
REQ-009 busy  output  1  high while in SCAN or DONE.
REQ-010 done  output  1  one-cycle pulse when data is updated.

Function
REQ-011 The FSM SHALL have states IDLE, SCAN, DONE, encoded in 2 bits; the unused encoding SHALL go to IDLE on the next edge.
REQ-012 IDLE with start=1 and abort=0: next state SCAN, sel=0, wait counter=0, shadow register cleared.
REQ-013 In SCAN, each cycle: if wait counter == SETTLE-1, capture mux_out into shadow[sel] and clear the counter, otherwise increment the counter.
REQ-014 On capture with sel<3, sel SHALL increment by 1; on capture with sel==3, next state SHALL be DONE and sel SHALL return to 0.
REQ-015 In DONE, data SHALL load the complete shadow value (including the bit-3 capture), done SHALL be 1 for exactly that cycle, and next state SHALL be IDLE.
REQ-016 Latency: start accepted at edge T gives done high in cycle T+4*SETTLE+1; back-to-back start is accepted no earlier than the first IDLE cycle after DONE.
REQ-017 start while busy SHALL be ignored (not queued).
REQ-018 abort in SCAN SHALL force IDLE on the next edge, with sel=0, counter=0, data unchanged, and done not asserted.
REQ-019 abort in DONE SHALL have no effect; the result still publishes.
REQ-020 start and abort together in IDLE: abort wins and the FSM stays in IDLE.
REQ-021 sel SHALL hold stable for exactly SETTLE cycles per channel and SHALL be 0 whenever the FSM is in IDLE.
REQ-022 data SHALL change only in DONE.

Reset
REQ-023 rst=1 SHALL immediately, without a clock, force state=IDLE, sel=0, data=0, busy=0, done=0, counter=0, shadow=0.
REQ-024 Reset asserted mid-scan SHALL discard the partial result; the first scan after deassertion requires a new start.

Configuration
REQ-025 Macro MUX_SCAN_CONT_EN defined: DONE SHALL go directly to SCAN (sel=0, counter=0) instead of IDLE, so scans repeat continuously until abort; start is still required to begin the first scan.
REQ-026 Macro MUX_SCAN_CONT_EN not defined: behaviour is single-shot per REQ-015.
REQ-027 In continuous mode, abort in DONE SHALL still publish the result and then go to IDLE.

Verification
REQ-028 SETTLE=1, mux inputs 4'b1010 modelled from sel, start pulse at cycle 2 -> sel sequence 0,1,2,3 in cycles 3..6, done in cycle 7, data=4'b1010.
REQ-029 SETTLE=3, inputs 4'b0110 -> each sel value held 3 cycles, done exactly 13 cycles after the start edge, data=4'b0110.
REQ-030 SETTLE=1, abort while sel==2 -> next cycle IDLE, sel=0, no done, data keeps its prior value 4'b1010.
REQ-031 start held high continuously, inputs 4'b1111 -> scans back-to-back with one IDLE cycle between each done, data=4'b1111; start and abort together in IDLE -> busy stays 0.
REQ-032 rst asserted asynchronously between clock edges mid-SCAN -> all outputs go to 0 before the next edge; no done after release.
REQ-033 With MUX_SCAN_CONT_EN, single start pulse, inputs changed from 4'b0001 to 4'b1000 between scans -> consecutive done pulses every 5 cycles, data goes 4'b0001 then 4'b1000.
